// File: rtl/conv_layer_input_ctrl_if.sv
// Handshake bundle between the layer top / input interface and the
// conv_layer_input_ctrl sequencer.
//   master : the sequencer (drives cmd/enable/status, receives start/abort/ready/ack)
//   slave  : the environment (layer top + input interface + kernel array)
// Signals:
//   start, abort, conv_ready : control from layer top / kernel array
//   ack[1:0]                 : completion code from the input interface
//   cmd[1:0], enable         : command pulse and enable to the input interface
//   busy, done, err          : status to layer top
//   row_valid, row_idx       : per-row completion pulse and row index
interface conv_layer_input_ctrl_if #(
  parameter int ROW_W = 4
) ();
  logic             start;
  logic             abort;
  logic             conv_ready;
  logic [1:0]       ack;
  logic [1:0]       cmd;
  logic             enable;
  logic             busy;
  logic             done;
  logic             err;
  logic             row_valid;
  logic [ROW_W-1:0] row_idx;

  modport master (
    input  start, abort, conv_ready, ack,
    output cmd, enable, busy, done, err, row_valid, row_idx
  );

  modport slave (
    output start, abort, conv_ready, ack,
    input  cmd, enable, busy, done, err, row_valid, row_idx
  );
endinterface

// File: rtl/conv_layer_input_ctrl.sv
// Sequencer for the conv layer input interface. Steps one image of OUT_ROWS
// output rows: PRELOAD once, then per row SHIFT (gated by conv_ready) and,
// except after the last row, LOAD. Each issued command waits for its matching
// ack code; a per-command watchdog moves to an error state if it never comes.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : asynchronous active-high reset
//   bus  : conv_layer_input_ctrl_if.master (start/abort/conv_ready/ack in,
//          cmd/enable/busy/done/err/row_valid/row_idx out)
// All outputs are registers or pure decodes of the state register.
module conv_layer_input_ctrl #(
  parameter int OUT_ROWS = 8,
  parameter int ROW_W    = 4,
  parameter int TIMEOUT  = 1024,
  parameter int TMO_W    = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  conv_layer_input_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE_CMD, S_PRE_WAIT, S_STALL, S_SH_CMD,
    S_SH_WAIT, S_LD_CMD, S_LD_WAIT, S_DONE, S_ERR
  } state_e;

  localparam logic [1:0] CODE_PRE = 2'd1;
  localparam logic [1:0] CODE_SH  = 2'd2;
  localparam logic [1:0] CODE_LD  = 2'd3;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_ROWS - 1);
  localparam bit               WD_EN    = (TIMEOUT != 0);
  localparam int               WD_LIM_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TMO_W-1:0] WD_LIM   = TMO_W'(WD_LIM_I);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_idx_q, row_idx_d;
  logic               row_valid_q, row_valid_d;
  logic [TMO_W-1:0]   wdog_q, wdog_d;
  logic               wd_hit;

  // Watchdog fires on the last allowed WAIT cycle without the expected ack.
  assign wd_hit = WD_EN && (wdog_q == WD_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_idx_q   <= '0;
      row_valid_q <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      row_valid_q <= row_valid_d;
      wdog_q      <= wdog_d;
    end
  end

  // Watchdog defaults to zero, so it is already cleared on entry to any WAIT
  // state; it only counts up while sitting in a WAIT without the right ack.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    row_valid_d = 1'b0;
    wdog_d      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_PRE_CMD;
          row_idx_d = '0;
        end
      end
      S_PRE_CMD: state_d = S_PRE_WAIT;
      S_PRE_WAIT: begin
        if (bus.ack == CODE_PRE) state_d = S_STALL;
        else if (wd_hit)         state_d = S_ERR;
        else                     wdog_d  = wdog_q + TMO_W'(1);
      end
      S_STALL: begin
        if (bus.conv_ready) state_d = S_SH_CMD;
      end
      S_SH_CMD: state_d = S_SH_WAIT;
      S_SH_WAIT: begin
        if (bus.ack == CODE_SH) begin
          row_valid_d = 1'b1;
          state_d     = (row_idx_q == LAST_ROW) ? S_DONE : S_LD_CMD;
        end else if (wd_hit) begin
          state_d = S_ERR;
        end else begin
          wdog_d = wdog_q + TMO_W'(1);
        end
      end
      S_LD_CMD: state_d = S_LD_WAIT;
      S_LD_WAIT: begin
        if (bus.ack == CODE_LD) begin
          row_idx_d = row_idx_q + ROW_W'(1);
          state_d   = S_STALL;
        end else if (wd_hit) begin
          state_d = S_ERR;
        end else begin
          wdog_d = wdog_q + TMO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything decided above, including a same-cycle ack
    // that would otherwise raise row_valid or reach S_DONE.
    if (bus.abort) begin
      state_d     = S_IDLE;
      row_valid_d = 1'b0;
      wdog_d      = '0;
      row_idx_d   = row_idx_q;
    end
  end

  // Moore decodes: cmd exists only during the one-cycle *_CMD states.
  always_comb begin
    bus.cmd = 2'd0;
    unique case (state_q)
      S_PRE_CMD: bus.cmd = CODE_PRE;
      S_SH_CMD:  bus.cmd = CODE_SH;
      S_LD_CMD:  bus.cmd = CODE_LD;
      default:   bus.cmd = 2'd0;
    endcase
  end

  assign bus.enable    = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign bus.busy      = !(state_q inside {S_IDLE, S_ERR});
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = (state_q == S_ERR);
  assign bus.row_valid = row_valid_q;
  assign bus.row_idx   = row_idx_q;

endmodule

// File: tb/tb_conv_layer_input_ctrl.sv
// Directed bench for conv_layer_input_ctrl (OUT_ROWS=3, TIMEOUT=16).
// Inputs change right after a negedge; outputs are observed at the negedge.
module tb_conv_layer_input_ctrl;
  localparam int OUT_ROWS = 3;
  localparam int ROW_W    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_layer_input_ctrl_if #(.ROW_W(ROW_W)) bus ();

  conv_layer_input_ctrl #(
    .OUT_ROWS(OUT_ROWS), .ROW_W(ROW_W), .TIMEOUT(16), .TMO_W(5)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // monitor state
  logic [31:0] cmd_hist;
  logic [31:0] rv_hist;
  int          n_cmd, n_rv, n_done, n_sh_ack;
  // ack model state
  bit          ack_auto, abort_at_last, abort_fired, pre_fin_seen;
  int          am_cnt;
  logic [1:0]  am_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    cmd_hist = '0; rv_hist = '0;
    n_cmd = 0; n_rv = 0; n_done = 0; n_sh_ack = 0;
    am_cnt = 0; abort_fired = 0; pre_fin_seen = 0;
  endtask

  // One cycle: observe outputs, then run the auto ack model, which answers
  // each command 4 cycles after it is seen.
  task automatic tick();
    @(negedge clk);
    if (bus.cmd != 2'd0) begin cmd_hist = {cmd_hist[29:0], bus.cmd}; n_cmd++; end
    if (bus.row_valid) begin rv_hist = {rv_hist[27:0], bus.row_idx}; n_rv++; end
    if (bus.done) n_done++;
    if (ack_auto) begin
      bus.ack = 2'd0;
      if (am_cnt != 0) begin
        am_cnt--;
        if (am_cnt == 0) begin
          bus.ack = am_code;
          if (am_code == 2'd1) pre_fin_seen = 1;
          if (am_code == 2'd2) n_sh_ack++;
          if (abort_at_last && am_code == 2'd2 && n_sh_ack == OUT_ROWS) begin
            bus.abort = 1'b1;
            abort_fired = 1;
          end
        end
      end
      if (bus.cmd != 2'd0) begin am_cnt = 4; am_code = bus.cmd; end
    end
  endtask

  task automatic run_done(input int budget, output bit ok, output bit rv_with_done);
    ok = 0; rv_with_done = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.done) begin ok = 1; rv_with_done = bus.row_valid; break; end
    end
  endtask

  task automatic man_ack(input logic [1:0] code);
    bus.ack = code; tick(); bus.ack = 2'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit ok, rvd;
    int bad;
    bus.start = 0; bus.abort = 0; bus.conv_ready = 1; bus.ack = 2'd0;
    ack_auto = 0; abort_at_last = 0;
    clr_mon();

    // reset state
    tick(); tick();
    chk("rst_cmd", 32'(bus.cmd), 0);
    chk("rst_en", 32'(bus.enable), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_rv", 32'(bus.row_valid), 0);
    chk("rst_idx", 32'(bus.row_idx), 0);
    rst = 0;
    tick();

    // 1: full image, auto ack
    clr_mon(); ack_auto = 1;
    bus.start = 1; tick(); bus.start = 0;
    chk("t1_start_lat", 32'(bus.cmd), 1);
    run_done(200, ok, rvd);
    chk("t1_done", 32'(ok), 1);
    chk("t1_done_with_rv", 32'(rvd), 1);
    chk("t1_cmd_seq", cmd_hist & 32'hFFF, 32'h6EE);
    chk("t1_ncmd", 32'(n_cmd), 6);
    chk("t1_nrv", 32'(n_rv), 3);
    chk("t1_rv_idx", rv_hist & 32'hFFF, 32'h012);
    tick();
    chk("t1_done_pulse", 32'(bus.done), 0);
    chk("t1_idle_busy", 32'(bus.busy), 0);

    // 2: conv_ready held low after PRELOAD_FIN
    clr_mon(); bus.conv_ready = 0;
    bus.start = 1; tick(); bus.start = 0;
    for (int i = 0; i < 50 && !pre_fin_seen; i++) tick();
    chk("t2_pre_fin", 32'(pre_fin_seen), 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.cmd != 2'd0 || !bus.busy) bad++;
    end
    chk("t2_stall", 32'(bad), 0);
    bus.conv_ready = 1; tick();
    chk("t2_shift", 32'(bus.cmd), 2);
    run_done(200, ok, rvd);
    chk("t2_done", 32'(ok), 1);

    // 3: mismatched ack, then multi-cycle SHIFT_FIN
    tick(); clr_mon(); ack_auto = 0; bus.ack = 2'd0;
    bus.start = 1; tick(); bus.start = 0;
    tick();
    man_ack(2'd1);        // -> S_STALL
    tick(); tick();       // S_SH_CMD, S_SH_WAIT
    bus.ack = 2'd3; tick();
    chk("t3_mis_rv", 32'(bus.row_valid), 0);
    chk("t3_mis_cmd", 32'(bus.cmd), 0);
    bus.ack = 2'd2; tick(); tick(); tick();
    bus.ack = 2'd0; tick();
    chk("t3_nrv", 32'(n_rv), 1);
    chk("t3_cmds", cmd_hist & 32'h3F, 32'h1B);
    chk("t3_ncmd", 32'(n_cmd), 3);
    bus.abort = 1; tick(); bus.abort = 0;
    chk("t3_abort_busy", 32'(bus.busy), 0);

    // 4: watchdog on missing LOAD_FIN
    clr_mon();
    bus.start = 1; tick(); bus.start = 0;
    tick();
    man_ack(2'd1);
    tick(); tick();
    man_ack(2'd2);        // observed in S_LD_CMD
    tick();               // first S_LD_WAIT cycle
    for (int i = 0; i < 15; i++) tick();
    chk("t4_err_early", 32'(bus.err), 0);
    tick();
    chk("t4_err", 32'(bus.err), 1);
    chk("t4_busy", 32'(bus.busy), 0);
    chk("t4_en", 32'(bus.enable), 0);
    tick(); tick(); tick();
    chk("t4_err_hold", 32'(bus.err), 1);
    bus.abort = 1; tick(); bus.abort = 0;
    chk("t4_abort_err", 32'(bus.err), 0);
    chk("t4_abort_busy", 32'(bus.busy), 0);
    clr_mon(); ack_auto = 1;
    bus.start = 1; tick(); bus.start = 0;
    run_done(200, ok, rvd);
    chk("t4_relaunch_done", 32'(ok), 1);
    chk("t4_relaunch_nrv", 32'(n_rv), 3);

    // 5: abort together with the last SHIFT_FIN
    tick(); clr_mon(); abort_at_last = 1;
    bus.start = 1; tick(); bus.start = 0;
    for (int i = 0; i < 200 && !abort_fired; i++) tick();
    chk("t5_fired", 32'(abort_fired), 1);
    tick(); bus.abort = 0; abort_at_last = 0;
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_rv", 32'(bus.row_valid), 0);
    chk("t5_cmd", 32'(bus.cmd), 0);
    tick(); tick();
    chk("t5_ndone", 32'(n_done), 0);
    chk("t5_nrv", 32'(n_rv), 2);

    // 6: async reset mid S_SH_WAIT of row 1
    clr_mon(); ack_auto = 0; bus.ack = 2'd0;
    bus.start = 1; tick(); bus.start = 0;
    tick();
    man_ack(2'd1);
    tick(); tick();
    man_ack(2'd2);
    tick();
    man_ack(2'd3);        // row_idx -> 1, S_STALL
    tick(); tick();       // S_SH_CMD, S_SH_WAIT
    chk("t6_pre_idx", 32'(bus.row_idx), 1);
    chk("t6_pre_busy", 32'(bus.busy), 1);
    #2 rst = 1;
    #1;
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_en", 32'(bus.enable), 0);
    chk("t6_rst_idx", 32'(bus.row_idx), 0);
    chk("t6_rst_cmd", 32'(bus.cmd), 0);
    tick(); rst = 0;
    bus.start = 1; tick(); bus.start = 0;
    chk("t6_restart_cmd", 32'(bus.cmd), 1);
    chk("t6_restart_idx", 32'(bus.row_idx), 0);
    bus.abort = 1; tick(); bus.abort = 0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
